// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-cycle accumulator ALU: opcodes, FSM states
// and the default datapath width.
package alu_seq_pkg;

  localparam int DEF_REG_WIDTH = 12;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_PASSB = 3'b010,
    OP_INC   = 3'b011,
    OP_CLR   = 3'b100,
    OP_MUL   = 3'b101,
    OP_SHL   = 3'b110,
    OP_SHR   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_MUL   = 2'b01,
    S_WRITE = 2'b10
  } state_e;

  function automatic logic is_multi_cycle(input op_e op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the control unit (master) and the ALU (slave),
// including the accumulator write port.
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int reg_width = DEF_REG_WIDTH
);

  logic                 start;
  op_e                  op;
  logic [reg_width-1:0] alu_a;
  logic [reg_width-1:0] alu_b;
  logic [reg_width-1:0] AC_in;
  logic                 ac_write_en;
  logic                 busy;
  logic                 done;
  logic                 cout;

  modport master (
    output start, op, alu_a, alu_b,
    input  AC_in, ac_write_en, busy, done, cout
  );

  modport slave (
    input  start, op, alu_a, alu_b,
    output AC_in, ac_write_en, busy, done, cout
  );

endinterface

// File: rtl/alu_seq_mul_step.sv
// One shift-add multiplication step: conditionally adds the (pre-shifted)
// multiplicand into the double-width partial product.
module alu_seq_mul_step #(
  parameter int width = 24
) (
  input  logic [width-1:0] acc,
  input  logic [width-1:0] mcand,
  input  logic             mbit,
  output logic [width-1:0] acc_next
);

  assign acc_next = mbit ? (acc + mcand) : acc;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU feeding the accumulator: single-cycle ops finish at the start
// edge, MUL iterates one multiplier bit per cycle, then one WRITE strobe.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int reg_width = DEF_REG_WIDTH
) (
  input  logic      clk,
  input  logic      reset,
  alu_seq_if.slave  bus
);

  localparam int                CNT_W    = (reg_width > 1) ? $clog2(reg_width) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(reg_width - 1);
  localparam int                PW       = 2 * reg_width;

  state_e               state;
  logic [CNT_W-1:0]     cnt;
  logic [PW-1:0]        acc;
  logic [PW-1:0]        mcand;
  logic [PW-1:0]        acc_next;
  logic [reg_width-1:0] mplier;
  logic [reg_width-1:0] ac_in_q;
  logic                 cout_q;
  logic                 we_q;
  logic                 busy_q;
  logic                 done_q;

  // Result in the low bits, carry/borrow/shifted-out bit in the MSB.
  function automatic logic [reg_width:0] alu_single(
    input op_e                  op,
    input logic [reg_width-1:0] a,
    input logic [reg_width-1:0] b
  );
    case (op)
      OP_ADD:   return {1'b0, a} + {1'b0, b};
      OP_SUB:   return {1'b0, a} - {1'b0, b};
      OP_PASSB: return {1'b0, b};
      OP_INC:   return {1'b0, a} + (reg_width + 1)'(1);
      OP_SHL:   return {a, 1'b0};
      OP_SHR:   return {a[0], 1'b0, a[reg_width-1:1]};
      default:  return '0;
    endcase
  endfunction

  alu_seq_mul_step #(
    .width (PW)
  ) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .mbit     (mplier[0]),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ac_in_q <= '0;
      cout_q  <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (is_multi_cycle(bus.op)) begin
              acc    <= '0;
              mcand  <= PW'(bus.alu_a);
              mplier <= bus.alu_b;
              cnt    <= '0;
              state  <= S_MUL;
            end else begin
              {cout_q, ac_in_q} <= alu_single(bus.op, bus.alu_a, bus.alu_b);
              we_q   <= 1'b1;
              done_q <= 1'b1;
              state  <= S_WRITE;
            end
          end
        end
        S_MUL: begin
          // The last step's sum goes straight to the result register.
          if (cnt == CNT_LAST) begin
            ac_in_q <= acc_next[reg_width-1:0];
            cout_q  <= |acc_next[PW-1:reg_width];
            we_q    <= 1'b1;
            done_q  <= 1'b1;
            state   <= S_WRITE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
        end
        S_WRITE: begin
          we_q   <= 1'b0;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          we_q   <= 1'b0;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.AC_in       = ac_in_q;
  assign bus.cout        = cout_q;
  assign bus.ac_write_en = we_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table of single/multi-cycle ops plus
// hand sequences for busy-start, mid-traffic reset and MUL abort.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk;
  logic reset;

  alu_seq_if #(.reg_width(12)) bus ();

  alu_seq #(.reg_width(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator model: latches only on the strobe, Z from the stored value.
  logic [11:0] ac_q;
  logic        ac_z;
  always @(posedge clk) begin
    if (reset)               ac_q <= 12'h000;
    else if (bus.ac_write_en) ac_q <= bus.AC_in;
  end
  assign ac_z = (ac_q == 12'h000);

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    op_e        op;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] res;
    logic        c;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  // Called at a negedge; returns at the negedge of the IDLE cycle after WRITE.
  task automatic do_op(input string nm, input op_e o, input logic [11:0] a, input logic [11:0] b,
                       input logic [11:0] er, input logic ec, input int elat);
    int lat;
    bus.start = 1'b1; bus.op = o; bus.alu_a = a; bus.alu_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.ac_write_en && lat < 40) begin
      check({nm, " busy"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(elat));
    check({nm, " AC_in"}, 32'(bus.AC_in), 32'(er));
    check({nm, " cout"}, 32'(bus.cout), 32'(ec));
    check({nm, " done"}, 32'(bus.done), 32'd1);
    @(negedge clk);
    check({nm, " strobe low"}, 32'(bus.ac_write_en), 32'd0);
    check({nm, " idle"}, 32'(bus.busy), 32'd0);
    check({nm, " AC model"}, 32'(ac_q), 32'(er));
    check({nm, " Z"}, 32'(ac_z), 32'(er == 12'h000));
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, " AC_in"}, 32'(bus.AC_in), 32'h000);
    check({nm, " we"}, 32'(bus.ac_write_en), 32'd0);
    check({nm, " busy"}, 32'(bus.busy), 32'd0);
    check({nm, " done"}, 32'(bus.done), 32'd0);
    check({nm, " cout"}, 32'(bus.cout), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int strobes;
    int strobe_cyc;
    logic [11:0] strobe_val;
    logic        strobe_c;

    vecs[0]  = '{OP_ADD,   12'hFFF, 12'h001, 12'h000, 1'b1, 1};
    vecs[1]  = '{OP_SUB,   12'h005, 12'h007, 12'hFFE, 1'b1, 1};
    vecs[2]  = '{OP_INC,   12'h7FF, 12'h000, 12'h800, 1'b0, 1};
    vecs[3]  = '{OP_PASSB, 12'h123, 12'hABC, 12'hABC, 1'b0, 1};
    vecs[4]  = '{OP_CLR,   12'h555, 12'h0AA, 12'h000, 1'b0, 1};
    vecs[5]  = '{OP_SHL,   12'h801, 12'h000, 12'h002, 1'b1, 1};
    vecs[6]  = '{OP_SHR,   12'hFFE, 12'h000, 12'h7FF, 1'b0, 1};
    vecs[7]  = '{OP_ADD,   12'h123, 12'h456, 12'h579, 1'b0, 1};
    vecs[8]  = '{OP_SUB,   12'h007, 12'h005, 12'h002, 1'b0, 1};
    vecs[9]  = '{OP_INC,   12'hFFF, 12'h000, 12'h000, 1'b1, 1};
    vecs[10] = '{OP_MUL,   12'h012, 12'h00A, 12'h0B4, 1'b0, 13};
    vecs[11] = '{OP_MUL,   12'h100, 12'h010, 12'h000, 1'b1, 13};
    vecs[12] = '{OP_MUL,   12'hFFF, 12'hFFF, 12'h001, 1'b1, 13};
    vecs[13] = '{OP_MUL,   12'h040, 12'h020, 12'h800, 1'b0, 13};
    vecs[14] = '{OP_SHL,   12'h3FF, 12'h000, 12'h7FE, 1'b0, 1};

    reset = 1'b1;
    bus.start = 1'b0; bus.op = OP_ADD; bus.alu_a = '0; bus.alu_b = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset_state("por");
    reset = 1'b0;

    for (int i = 0; i < 15; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].res, vecs[i].c, vecs[i].lat);

    // Start accepted in the IDLE cycle right after the previous WRITE.
    do_op("b2b add", OP_ADD, 12'h001, 12'h002, 12'h003, 1'b0, 1);
    do_op("b2b inc", OP_INC, 12'h00F, 12'h000, 12'h010, 1'b0, 1);

    // Ignored starts during MUL and WRITE; operands changed mid-MUL.
    bus.start = 1'b1; bus.op = OP_MUL; bus.alu_a = 12'h012; bus.alu_b = 12'h00A;
    strobes = 0; strobe_cyc = 0; strobe_val = '0; strobe_c = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.alu_a = 12'hFFF; bus.alu_b = 12'hFFF;
      if (k == 3) begin bus.start = 1'b1; bus.op = OP_ADD; end
      if (bus.ac_write_en) begin
        strobes++;
        strobe_cyc = k;
        strobe_val = bus.AC_in;
        strobe_c = bus.cout;
        bus.start = 1'b1; bus.op = OP_ADD;
      end
    end
    check("busy-start strobes", 32'(strobes), 32'd1);
    check("busy-start cycle", 32'(strobe_cyc), 32'd13);
    check("busy-start AC_in", 32'(strobe_val), 32'h0B4);
    check("busy-start cout", 32'(strobe_c), 32'd0);
    check("busy-start AC model", 32'(ac_q), 32'h0B4);

    // Reset held two cycles in the middle of a MUL.
    bus.start = 1'b1; bus.op = OP_MUL; bus.alu_a = 12'h100; bus.alu_b = 12'h010;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_state("mid reset");
    reset = 1'b0;

    // Prime a nonzero result, then abort a MUL at its fifth cycle.
    do_op("pre-abort", OP_PASSB, 12'h000, 12'h5A5, 12'h5A5, 1'b0, 1);
    bus.start = 1'b1; bus.op = OP_MUL; bus.alu_a = 12'h012; bus.alu_b = 12'h00A;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("abort in MUL", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("abort");
    strobes = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.ac_write_en) strobes++;
    end
    check("abort strobes", 32'(strobes), 32'd0);

    do_op("post-abort shr", OP_SHR, 12'h001, 12'h000, 12'h000, 1'b1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
